// File: rtl/add_serial_pkg.sv
// Shared types and constants for the bit-serial adder arbiter.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller state encoding (IDLE=0, ADD=1, DONE=2)
//   maj3          : majority of three bits (full-adder carry)
package add_serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/add_serial_arb_if.sv
// Request/result bus between the two requesters, the consumer and add_serial_arb.
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   a0,b0 / a1,b1       : operands of requester 0 / 1
//   res_valid/res_ready : result handshake
//   res_data/res_carry  : sum modulo 2^WIDTH and carry out of the MSB
//   res_id              : requester owning the result
// master = requester/consumer side, slave = adder side.
interface add_serial_arb_if #(
  parameter int unsigned WIDTH = add_serial_pkg::DEFAULT_WIDTH
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             res_id;

  modport master (
    output req_valid, a0, b0, a1, b1, res_ready,
    input  req_ready, res_valid, res_data, res_carry, res_id
  );

  modport slave (
    input  req_valid, a0, b0, a1, b1, res_ready,
    output req_ready, res_valid, res_data, res_carry, res_id
  );

endinterface

// File: rtl/add_serial_core.sv
// Bit-serial adder datapath: one operand bit pair per step, LSB first.
//   clk, rst    : clock, synchronous active-low reset
//   load        : capture a_in/b_in, clear sum and carry
//   step        : consume one bit pair, shift the sum bit in at the MSB
//   a_in, b_in  : operands
//   out, carry  : accumulated sum and running carry
module add_serial_core
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sum_c;

  assign sum_c = a_reg[0] ^ b_reg[0] ^ carry;

  // After WIDTH steps the first sum bit has shifted down to bit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
      out   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      a_reg <= a_in;
      b_reg <= b_in;
      out   <= '0;
      carry <= 1'b0;
    end else if (step) begin
      out   <= {sum_c, out[WIDTH-1:1]};
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      carry <= maj3(a_reg[0], b_reg[0], carry);
    end
  end

endmodule

// File: rtl/add_serial_arb.sv
// Two-requester round-robin front end sharing one bit-serial adder.
//   clk : clock
//   rst : synchronous active-low reset
//   en  : global enable; blocks grants and freezes an addition in progress
//   bus : request/result interface (slave side)
module add_serial_arb
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  add_serial_arb_if.slave    bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic             prio;
  logic             id_q;
  logic             res_valid_q;
  logic             gnt_id;
  logic [1:0]       gnt_c;
  logic             xfer_c;
  logic             step_c;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] core_out;
  logic             core_carry;

  // Round-robin pick: the priority holder wins if valid, otherwise the other one.
  always_comb begin
    gnt_c  = 2'b00;
    gnt_id = prio;
    if (!bus.req_valid[prio]) gnt_id = ~prio;
    if ((state == IDLE) && en && rst)
      gnt_c = {gnt_id, ~gnt_id} & {2{bus.req_valid[gnt_id]}};
  end

  assign xfer_c = |gnt_c;
  assign step_c = (state == ADD) && en;
  assign a_sel  = gnt_id ? bus.a1 : bus.a0;
  assign b_sel  = gnt_id ? bus.b1 : bus.b0;

  // Controller: grant, count WIDTH enabled steps, hold result until taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      prio        <= 1'b0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer_c) begin
            state <= ADD;
            count <= '0;
            id_q  <= gnt_id;
            prio  <= ~gnt_id;
          end
        end
        ADD: begin
          if (en) begin
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state       <= DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  add_serial_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (xfer_c),
    .step  (step_c),
    .a_in  (a_sel),
    .b_in  (b_sel),
    .out   (core_out),
    .carry (core_carry)
  );

  // Core registers only change on load/step, so the result holds in DONE.
  assign bus.req_ready = gnt_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = core_out;
  assign bus.res_carry = core_carry;
  assign bus.res_id    = id_q;

endmodule

// File: tb/tb_add_serial_arb.sv
// Testbench for add_serial_arb: directed vector table, randomized transactions
// against an arithmetic/round-robin reference model, and a mid-operation reset.
module tb_add_serial_arb;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   checks = 0;
  int   errors = 0;
  logic model_prio;

  always #5 clk = ~clk;

  add_serial_arb_if #(.WIDTH(W)) bus ();

  add_serial_arb #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] a0, b0, a1, b1;
    int           stall_at;
    int           stall_len;
    int           bp;
    logic         exp_id;
    logic [W-1:0] exp_data;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[$];

  // At most one grant at any time.
  always @(negedge clk) begin
    checks++;
    if (bus.req_ready == 2'b11) begin
      errors++;
      $display("FAIL grant_onehot: req_ready=%b required at most one bit", bus.req_ready);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                              input logic [W-1:0] a1, input logic [W-1:0] b1, input int sa,
                              input int sl, input int bp, input logic id,
                              input logic [W-1:0] d, input logic c);
    vec_t r;
    r.valid = v; r.a0 = a0; r.b0 = b0; r.a1 = a1; r.b1 = b1;
    r.stall_at = sa; r.stall_len = sl; r.bp = bp;
    r.exp_id = id; r.exp_data = d; r.exp_carry = c;
    return r;
  endfunction

  // Reference: round-robin winner, then plain (W+1)-bit addition.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [W:0] s;
    r.exp_id = (v.valid == 2'b11) ? model_prio : v.valid[1];
    s = r.exp_id ? ((W+1)'(v.a1) + (W+1)'(v.b1)) : ((W+1)'(v.a0) + (W+1)'(v.b0));
    r.exp_data  = s[W-1:0];
    r.exp_carry = s[W];
    return r;
  endfunction

  task automatic pulse_reset();
    rst = 1'b0;
    en = 1'b1;
    bus.res_ready = 1'b0;
    bus.req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_prio = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_txn(input vec_t v);
    int  lat;
    int  limit;
    bit  seen;
    bus.req_valid = v.valid;
    bus.a0 = v.a0; bus.b0 = v.b0; bus.a1 = v.a1; bus.b1 = v.b1;
    bus.res_ready = 1'b0;
    en = 1'b1;
    #1;
    check("grant", 32'(bus.req_ready), 32'(2'b01 << v.exp_id));
    @(posedge clk);
    lat   = 0;
    seen  = 1'b0;
    limit = int'(W) + v.stall_len + 4;
    while (!seen && lat <= limit) begin
      @(negedge clk);
      if (lat == 1) check("no_grant_busy", 32'(bus.req_ready), 32'd0);
      if (v.stall_len > 0 && lat == v.stall_at) en = 1'b0;
      if (v.stall_len > 0 && lat == v.stall_at + v.stall_len) en = 1'b1;
      if (bus.res_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    en = 1'b1;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL res_valid_timeout: no result after %0d cycles, required %0d", lat, int'(W) + v.stall_len);
      pulse_reset();
      return;
    end
    check("latency", 32'(lat), 32'(int'(W) + v.stall_len));
    check("res_data", 32'(bus.res_data), 32'(v.exp_data));
    check("res_carry", 32'(bus.res_carry), 32'(v.exp_carry));
    check("res_id", 32'(bus.res_id), 32'(v.exp_id));
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", 32'(bus.res_valid), 32'd1);
      check("bp_data", 32'({bus.res_id, bus.res_carry, bus.res_data}),
            32'({v.exp_id, v.exp_carry, v.exp_data}));
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_consumed", 32'(bus.res_valid), 32'd0);
    model_prio = ~v.exp_id;
  endtask

  initial begin
    vec_t v;
    model_prio = 1'b0;
    rst = 1'b0;
    en = 1'b1;
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_outputs", 32'({bus.res_valid, bus.res_id, bus.res_carry, bus.res_data}), 32'd0);
    rst = 1'b1;
    en = 1'b0;
    #1;
    check("en_low_no_grant", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("en_low_idle", 32'(bus.res_valid), 32'd0);

    // valid, a0, b0, a1, b1, stall_at, stall_len, bp, id, data, carry
    vecs.push_back(mk(2'b01, 8'h3C, 8'h05, 8'h00, 8'h00, -1, 0, 0, 1'b0, 8'h41, 1'b0));
    vecs.push_back(mk(2'b10, 8'h00, 8'h00, 8'hFF, 8'h01, -1, 0, 0, 1'b1, 8'h00, 1'b1));
    vecs.push_back(mk(2'b11, 8'h12, 8'h34, 8'hF0, 8'h20, -1, 0, 0, 1'b0, 8'h46, 1'b0));
    vecs.push_back(mk(2'b11, 8'h12, 8'h34, 8'hF0, 8'h20, -1, 0, 0, 1'b1, 8'h10, 1'b1));
    vecs.push_back(mk(2'b11, 8'h12, 8'h34, 8'hF0, 8'h20, -1, 0, 0, 1'b0, 8'h46, 1'b0));
    vecs.push_back(mk(2'b01, 8'h80, 8'h80, 8'h00, 8'h00,  3, 3, 0, 1'b0, 8'h00, 1'b1));
    vecs.push_back(mk(2'b10, 8'h00, 8'h00, 8'hA5, 8'h5A, -1, 0, 5, 1'b1, 8'hFF, 1'b0));
    foreach (vecs[i]) run_txn(vecs[i]);

    for (int n = 0; n < 40; n++) begin
      v.valid = 2'($urandom_range(1, 3));
      v.a0 = W'($urandom); v.b0 = W'($urandom);
      v.a1 = W'($urandom); v.b1 = W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        v.stall_at  = int'($urandom_range(1, W - 1));
        v.stall_len = int'($urandom_range(1, 3));
      end else begin
        v.stall_at  = -1;
        v.stall_len = 0;
      end
      v.bp = int'($urandom_range(0, 3));
      run_txn(model(v));
    end

    // Leave priority with requester 1, then abort an addition with reset.
    run_txn(mk(2'b01, 8'h03, 8'h04, 8'h00, 8'h00, -1, 0, 0, 1'b0, 8'h07, 1'b0));
    bus.req_valid = 2'b10;
    bus.a1 = 8'h55; bus.b1 = 8'h22;
    #1;
    check("pre_abort_grant", 32'(bus.req_ready), 32'd2);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    check("req_ready_in_rst", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("abort_outputs", 32'({bus.res_valid, bus.res_id, bus.res_carry, bus.res_data}), 32'd0);
    #1;
    check("post_rst_prio0", 32'(bus.req_ready), 32'd1);
    model_prio = 1'b0;
    run_txn(mk(2'b11, 8'h10, 8'h20, 8'h55, 8'h22, -1, 0, 0, 1'b0, 8'h30, 1'b0));
    run_txn(mk(2'b11, 8'h10, 8'h20, 8'h55, 8'h22, -1, 0, 1, 1'b1, 8'h77, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
